adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 clk  input  1  single clock; all registered state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_1  input  WIDTH  first operand, unsigned/two's-complement agnostic.
REQ-005 in_2  input  WIDTH  second operand.
REQ-006 in_valid  input  1  qualifies in_1/in_2 for the registered path.
REQ-007 Sum_out  output  WIDTH  combinational sum of in_1 and in_2.
REQ-008 sum_q  output  WIDTH  registered sum.
REQ-009 out_valid  output  1  registered result valid.
REQ-010 carry_out  output  1  registered unsigned carry out of MSB.
REQ-011 overflow  output  1  registered signed two's-complement overflow.
REQ-012 zero  output  1  registered flag, sum equals zero.

Function
REQ-013 Sum_out SHALL equal (in_1 + in_2) mod 2^WIDTH, purely combinational, zero latency, independent of clk, rst_n and in_valid.
REQ-014 Sum_out SHALL wrap silently on overflow: 0xFFFFFFFF + 0x00000001 = 0x00000000.
REQ-015 On a rising clk edge with in_valid=1, sum_q SHALL load the Sum_out value; out_valid SHALL be 1 the following cycle (latency 1).
REQ-016 On a rising clk edge with in_valid=0, sum_q and flags SHALL hold; out_valid SHALL go 0.
REQ-017 carry_out SHALL be bit WIDTH of the (WIDTH+1)-bit unsigned sum, captured with sum_q.
REQ-018 overflow SHALL be 1 when in_1 and in_2 MSBs are equal and the sum MSB differs, captured with sum_q.
REQ-019 zero SHALL be 1 when the captured sum is all zeros, including wrap-to-zero cases.
REQ-020 Back-to-back in_valid SHALL produce one result per cycle with no stalls; no backpressure exists.

Reset
REQ-021 rst_n low SHALL immediately (asynchronously) clear sum_q, out_valid, carry_out, overflow, zero to 0.
REQ-022 Reset mid-stream SHALL discard any pending result; first result after release appears one cycle after the first in_valid edge sampled with rst_n high.
REQ-023 Sum_out SHALL remain a live combinational sum during reset.

Configuration
REQ-024 Macro ADDER_FLAGS_EN: when defined, carry_out, overflow, zero SHALL behave per REQ-017..019.
REQ-025 When ADDER_FLAGS_EN is undefined, carry_out, overflow, zero SHALL be tied to constant 0 and no flag registers SHALL be inferred; Sum_out, sum_q, out_valid unaffected.

Verification
REQ-026 in_1=0x00000000, in_2=0x00000000 -> Sum_out=0x00000000; after valid edge sum_q=0, zero=1, carry_out=0.
REQ-027 in_1=0x00000001, in_2=0x00000001 -> Sum_out=0x00000002; in_1=10, in_2=20 -> Sum_out=30 (0x0000001E).
REQ-028 in_1=0xFFFFFFFF, in_2=0x00000001 -> Sum_out=0x00000000; registered: carry_out=1, overflow=0, zero=1.
REQ-029 in_1=0x12345678, in_2=0x11111111 -> Sum_out=0x23456789; in_1=0x7FFFFFFF, in_2=0x00000001 -> sum_q=0x80000000, overflow=1, carry_out=0.
REQ-030 Stream 3 valid operand pairs then drop in_valid, assert rst_n=0 between edges -> sum_q, out_valid, flags clear immediately without a clock edge; Sum_out still tracks inputs.
REQ-031 Build without ADDER_FLAGS_EN, repeat REQ-028 -> carry_out=overflow=zero=0, sum_q=0x00000000, out_valid=1.

Source files
------------

// File: rtl/adder_if.sv
// Operand/result bundle for the adder: inputs from the requester, combinational
// and registered results back to it.
interface adder_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             in_valid;
  logic [WIDTH-1:0] Sum_out;
  logic [WIDTH-1:0] sum_q;
  logic             out_valid;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_1,
    output in_2,
    output in_valid,
    input  Sum_out,
    input  sum_q,
    input  out_valid,
    input  carry_out,
    input  overflow,
    input  zero
  );

  modport slave (
    input  in_1,
    input  in_2,
    input  in_valid,
    output Sum_out,
    output sum_q,
    output out_valid,
    output carry_out,
    output overflow,
    output zero
  );

endinterface

// File: rtl/adder.sv
// Adder with a live combinational sum and a one-cycle registered result.
// Define ADDER_FLAGS_EN to build the registered carry_out/overflow/zero flags.
module adder #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  adder_if.slave  bus
);

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] sum_q_r;
  logic             out_valid_r;

`ifdef ADDER_FLAGS_EN
  logic sum_carry_s;
  logic carry_r;
  logic overflow_r;
  logic zero_r;

  function automatic logic signed_overflow(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] s);
    return (s == {WIDTH{1'b0}});
  endfunction

  // One extra bit on the adder so the unsigned carry comes from the same sum.
  always_comb begin
    {sum_carry_s, sum_s} = {1'b0, bus.in_1} + {1'b0, bus.in_2};
  end

  // Flags are captured together with sum_q and hold while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else if (bus.in_valid) begin
      carry_r    <= sum_carry_s;
      overflow_r <= signed_overflow(bus.in_1, bus.in_2, sum_s);
      zero_r     <= is_zero(sum_s);
    end else begin
      carry_r    <= carry_r;
      overflow_r <= overflow_r;
      zero_r     <= zero_r;
    end
  end

  assign bus.carry_out = carry_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
`else
  // Plain modular sum; no carry bit is needed without the flags.
  always_comb begin
    sum_s = bus.in_1 + bus.in_2;
  end

  assign bus.carry_out = 1'b0;
  assign bus.overflow  = 1'b0;
  assign bus.zero      = 1'b0;
`endif

  // Result register: load on in_valid, otherwise hold sum and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q_r     <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      sum_q_r     <= sum_s;
      out_valid_r <= 1'b1;
    end else begin
      sum_q_r     <= sum_q_r;
      out_valid_r <= 1'b0;
    end
  end

  assign bus.Sum_out   = sum_s;
  assign bus.sum_q     = sum_q_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed vector table, reset sequences and
// randomized traffic against an arithmetic reference model.
module tb_adder;

  localparam int W = 32;

`ifdef ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  adder_if #(.WIDTH(W)) bus ();

  adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state for the registered outputs.
  logic [W-1:0] m_q;
  logic         m_valid;
  logic         m_carry;
  logic         m_ovf;
  logic         m_zero;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned t;
    t = 64'(a) + 64'(b);
    return t[W-1:0];
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned t;
    t = 64'(a) + 64'(b);
    return (t > 64'h0000_0000_FFFF_FFFF);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic model_reset();
    m_q     = 32'h0000_0000;
    m_valid = 1'b0;
    m_carry = 1'b0;
    m_ovf   = 1'b0;
    m_zero  = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sum_q"},     64'(bus.sum_q),     64'(m_q));
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(m_valid));
    check({tag, "_carry"},     64'(bus.carry_out), 64'(m_carry));
    check({tag, "_overflow"},  64'(bus.overflow),  64'(m_ovf));
    check({tag, "_zero"},      64'(bus.zero),      64'(m_zero));
  endtask

  // One clock: drive at negedge, check the combinational sum, then the registers after the edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic v, input string tag);
    @(negedge clk);
    bus.in_1     = a;
    bus.in_2     = b;
    bus.in_valid = v;
    #1;
    check({tag, "_Sum_out"}, 64'(bus.Sum_out), 64'(ref_sum(a, b)));
    @(posedge clk);
    if (v) begin
      m_q     = ref_sum(a, b);
      m_valid = 1'b1;
      m_carry = FLAGS && ref_carry(a, b);
      m_ovf   = FLAGS && ref_ovf(a, b);
      m_zero  = FLAGS && (ref_sum(a, b) == 32'h0000_0000);
    end else begin
      m_valid = 1'b0;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rv;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_000A, 32'h0000_0014, 32'h0000_001E, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};

    rst_n        = 1'b0;
    bus.in_1     = 32'h0000_0003;
    bus.in_2     = 32'h0000_0004;
    bus.in_valid = 1'b0;
    model_reset();

    // Reset state, and the combinational sum stays live during reset.
    #2;
    check_regs("reset");
    check("reset_Sum_out", 64'(bus.Sum_out), 64'(32'h0000_0007));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back to back.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].a, vecs[i].b, 1'b1, "vec");
      check("tbl_Sum_out",   64'(bus.Sum_out),   64'(vecs[i].sum));
      check("tbl_sum_q",     64'(bus.sum_q),     64'(vecs[i].sum));
      check("tbl_out_valid", 64'(bus.out_valid), 64'(1'b1));
      check("tbl_carry",     64'(bus.carry_out), 64'(FLAGS ? vecs[i].carry : 1'b0));
      check("tbl_overflow",  64'(bus.overflow),  64'(FLAGS ? vecs[i].ovf : 1'b0));
      check("tbl_zero",      64'(bus.zero),      64'(FLAGS ? vecs[i].zero : 1'b0));
    end

    // Idle cycles: result and flags hold, out_valid drops.
    step(32'h0000_1000, 32'h0000_2000, 1'b0, "hold1");
    step(32'hDEAD_BEEF, 32'h1234_0000, 1'b0, "hold2");
    check("hold_sum_q", 64'(bus.sum_q), 64'(32'hFFFF_FFFE));

    // Stream three results, drop in_valid, then reset between edges.
    step(32'h0000_0100, 32'h0000_0200, 1'b1, "strm");
    step(32'h7FFF_0000, 32'h0001_0000, 1'b1, "strm");
    step(32'hFFFF_FFF0, 32'h0000_0010, 1'b1, "strm");
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    bus.in_1 = 32'h0000_0005;
    bus.in_2 = 32'h0000_0007;
    #1;
    check("rst_Sum_out", 64'(bus.Sum_out), 64'(32'h0000_000C));
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_regs("rst_held");
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;

    // Nothing appears until the first valid edge after release.
    step(32'h0000_0001, 32'h0000_0002, 1'b0, "post_rst_idle");
    step(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "post_rst_first");
    check("post_rst_out_valid", 64'(bus.out_valid), 64'(1'b1));

    // Randomized traffic with biased operand choices.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ~ra + 32'h0000_0001;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = {1'b0, ra[30:0]};
        default: rb = $urandom;
      endcase
      rv = ($urandom_range(0, 3) != 0);
      step(ra, rb, rv, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
